// File: rtl/lab3_sweep_ctrl.sv
// lab3_sweep_ctrl: on-chip self-check sequencer for the 3-input lab3 block.
// It drives {a,b,c} through vectors 0..7 and holds each vector for DWELL settle cycles.
// It then spends one CHECK cycle comparing x/y against the EXP_X/EXP_Y truth tables.
// It reports busy/done/pass, a saturating error count, and the first failing vector.
// Optional build macro: LAB3_SWEEP_STOP_ON_FAIL_EN. When it is defined, the first
// mismatch ends the sweep immediately.
module lab3_sweep_ctrl #(
    parameter int         DWELL = 2,
    parameter logic [7:0] EXP_X = 8'h96,
    parameter logic [7:0] EXP_Y = 8'hE8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       x,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic       fail,
    output logic [2:0] first_fail
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] idx;
    logic [3:0] cnt;
    logic [3:0] err_q;
    logic       fail_q;
    logic [2:0] first_q;
    logic [2:0] vec;
    logic       mismatch;

    // Error count stops at 8, the number of vectors in one sweep.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= 4'd8) ? 4'd8 : v + 4'd1;
    endfunction

    // The comparison result is only acted on in CHECK; elsewhere it is ignored.
    assign mismatch = (x != EXP_X[idx]) || (y != EXP_Y[idx]);

    // State register; rst overrides everything, including a sweep in flight.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic plus the state-decoded outputs (vector drive, busy, done).
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        vec       = 3'd0;
        case (state)
            IDLE: begin
                if (start) state_nxt = SETTLE;
            end
            SETTLE: begin
                busy = 1'b1;
                vec  = idx;
                if (cnt == DWELL_LAST) state_nxt = CHECK;
            end
            CHECK: begin
                busy = 1'b1;
                vec  = idx;
                if (idx == 3'd7) state_nxt = DONE;
                else             state_nxt = SETTLE;
`ifdef LAB3_SWEEP_STOP_ON_FAIL_EN
                if (mismatch) state_nxt = DONE;
`endif
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = SETTLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sweep counters and result flags; a start from IDLE or DONE clears them.
    // During a sweep (SETTLE/CHECK) start is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= 3'd0;
            cnt     <= 4'd0;
            err_q   <= 4'd0;
            fail_q  <= 1'b0;
            first_q <= 3'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx     <= 3'd0;
                        cnt     <= 4'd0;
                        err_q   <= 4'd0;
                        fail_q  <= 1'b0;
                        first_q <= 3'd0;
                    end
                end
                SETTLE: begin
                    cnt <= cnt + 4'd1;
                end
                CHECK: begin
                    cnt <= 4'd0;
                    if (idx != 3'd7) idx <= idx + 3'd1;
                    if (mismatch) begin
                        err_q <= sat_inc(err_q);
                        if (!fail_q) begin
                            fail_q  <= 1'b1;
                            first_q <= idx;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign {a, b, c}  = vec;
    assign err_count  = err_q;
    assign fail       = fail_q;
    assign first_fail = first_q;
    assign pass       = done && (err_q == 4'd0);

endmodule

// File: tb/tb_lab3_sweep_ctrl.sv
// Testbench for lab3_sweep_ctrl.
// A behavioural lab3 model (x = parity, y = majority) has fault injection hooks.
// A table of whole-sweep scenarios is followed by hand-written reset and restart sequences.
module tb_lab3_sweep_ctrl;

    localparam int DWELL = 2;
    localparam int TMO   = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       a, b, c, x, y;
    logic       busy, done, pass, fail;
    logic [3:0] err_count;
    logic [2:0] first_fail;

    // lab3 model with fault hooks
    logic       y_zero;
    logic [7:0] x_inv;

    int checks = 0;
    int errors = 0;

    lab3_sweep_ctrl #(.DWELL(DWELL), .EXP_X(8'h96), .EXP_Y(8'hE8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a(a), .b(b), .c(c), .x(x), .y(y),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail(fail), .first_fail(first_fail)
    );

    always #5 clk = ~clk;

    assign x = (a ^ b ^ c) ^ x_inv[{a, b, c}];
    assign y = y_zero ? 1'b0 : ((a & b) | (a & c) | (b & c));

    typedef struct {
        string      name;
        logic       yz;
        logic [7:0] xi;
        int         p1;
        int         p2;
        int         exp_busy;
        int         exp_err;
        int         exp_fail;
        int         exp_first;
        int         exp_pass;
    } scen_t;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Follows a sweep while busy: checks each cycle's vector and optionally
    // re-pulses start at busy-cycle indices p1/p2.
    task automatic run_busy(input int p1, input int p2, output int cycles, output int abc_err);
        cycles  = 0;
        abc_err = 0;
        while (busy && cycles < TMO) begin
            if ({a, b, c} != 3'(cycles / (DWELL + 1))) abc_err++;
            start = (cycles == p1) || (cycles == p2);
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;
        if (cycles >= TMO) begin
            errors++;
            $display("FAIL sweep_timeout: busy still high after %0d cycles", cycles);
        end
    endtask

    scen_t tbl[4];
    int    cyc, aerr;

    initial begin
        tbl[0] = '{"clean",        1'b0, 8'h00, -1, -1, 24, 0, 0, 0, 1};
`ifdef LAB3_SWEEP_STOP_ON_FAIL_EN
        tbl[1] = '{"y_stuck0",     1'b1, 8'h00, -1, -1, 12, 1, 1, 3, 0};
        tbl[3] = '{"x_inv_vec5",   1'b0, 8'h20, -1, -1, 18, 1, 1, 5, 0};
`else
        tbl[1] = '{"y_stuck0",     1'b1, 8'h00, -1, -1, 24, 4, 1, 3, 0};
        tbl[3] = '{"x_inv_vec5",   1'b0, 8'h20, -1, -1, 24, 1, 1, 5, 0};
`endif
        tbl[2] = '{"start_ignored", 1'b0, 8'h00, 5, 17, 24, 0, 0, 0, 1};

        rst = 1'b1; start = 1'b0; y_zero = 1'b0; x_inv = 8'h00;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_err", int'(err_count), 0);
        chk("rst_fail", int'(fail), 0);
        chk("rst_first", int'(first_fail), 0);
        chk("rst_abc", int'({a, b, c}), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven sweeps
        for (int i = 0; i < 4; i++) begin
            y_zero = tbl[i].yz;
            x_inv  = tbl[i].xi;
            pulse_start();
            run_busy(tbl[i].p1, tbl[i].p2, cyc, aerr);
            chk({tbl[i].name, "_busy_cycles"}, cyc, tbl[i].exp_busy);
            chk({tbl[i].name, "_abc_seq_errs"}, aerr, 0);
            chk({tbl[i].name, "_done"}, int'(done), 1);
            chk({tbl[i].name, "_abc_idle"}, int'({a, b, c}), 0);
            chk({tbl[i].name, "_pass"}, int'(pass), tbl[i].exp_pass);
            chk({tbl[i].name, "_err"}, int'(err_count), tbl[i].exp_err);
            chk({tbl[i].name, "_fail"}, int'(fail), tbl[i].exp_fail);
            chk({tbl[i].name, "_first"}, int'(first_fail), tbl[i].exp_first);
            repeat (2) @(posedge clk);
            #1;
            chk({tbl[i].name, "_done_holds"}, int'(done), 1);
        end

        // Failing sweep, then restart from DONE with a correct model
        y_zero = 1'b1; x_inv = 8'h00;
        pulse_start();
        run_busy(-1, -1, cyc, aerr);
        chk("prefail_fail", int'(fail), 1);
        y_zero = 1'b0;
        pulse_start();
        chk("restart_done", int'(done), 0);
        chk("restart_busy", int'(busy), 1);
        chk("restart_err", int'(err_count), 0);
        chk("restart_fail", int'(fail), 0);
        chk("restart_first", int'(first_fail), 0);
        run_busy(-1, -1, cyc, aerr);
        chk("restart_cycles", cyc, 24);
        chk("restart_pass", int'(pass), 1);
        chk("restart_err_end", int'(err_count), 0);

        // rst mid-sweep while idx=4
`ifdef LAB3_SWEEP_STOP_ON_FAIL_EN
        y_zero = 1'b0;
`else
        y_zero = 1'b1;
`endif
        pulse_start();
        cyc = 0;
        while (!({a, b, c} == 3'd4 && busy) && cyc < TMO) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("reach_idx4_cycle", cyc, 12);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_abc", int'({a, b, c}), 0);
        chk("midrst_err", int'(err_count), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_fail", int'(fail), 0);
        rst = 1'b0; y_zero = 1'b0;
        @(posedge clk); #1;
        chk("midrst_idle_busy", int'(busy), 0);
        pulse_start();
        run_busy(-1, -1, cyc, aerr);
        chk("post_rst_cycles", cyc, 24);
        chk("post_rst_abc_seq", aerr, 0);
        chk("post_rst_pass", int'(pass), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
